// File: rtl/pwm_timer_pkg.sv
// Shared definitions for the multi-channel PWM timer: register map, CTRL bit
// positions and the counter direction type.
package pwm_timer_pkg;

    localparam int A_CTRL = 0;
    localparam int A_TOP  = 1;
    localparam int A_PSC  = 2;
    localparam int A_CMP0 = 3;

    localparam int CTRL_W   = 3;
    localparam int CTRL_EN  = 0;
    localparam int CTRL_CTR = 1;
    localparam int CTRL_OS  = 2;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_tmr_ch.sv
// One PWM compare channel: CMP shadow/active pair, compare against the shared
// counter and the registered, optionally inverted output.
module pwm_tmr_ch #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmp_wr,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             load,
    input  logic [CNT_W-1:0] cnt,
    input  logic             en,
    input  logic             inv,
    output logic             pwm
);

    logic [CNT_W-1:0] cmp_sh_reg;
    logic [CNT_W-1:0] cmp_act_reg;
    logic             pwm_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cmp_sh_reg  <= '0;
            cmp_act_reg <= '0;
            pwm_reg     <= 1'b0;
        end else begin
            if (cmp_wr)
                cmp_sh_reg <= wr_data;
            if (load)
                cmp_act_reg <= cmp_sh_reg;
            // en is the next-cycle enable, so the idle level appears together with running=0
            pwm_reg <= en ? ((cnt < cmp_act_reg) ^ inv) : inv;
        end
    end

    assign pwm = pwm_reg;

endmodule

// File: rtl/pwm_timer_mc.sv
// Multi-channel PWM timer: prescaler, shared edge/center-aligned period counter
// with double-buffered TOP/PSC, one-shot support and NCH compare channels.
module pwm_timer_mc
    import pwm_timer_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int CNT_W = 16,
    parameter  int PSC_W = 8,
    localparam int AW    = $clog2(NCH + 3)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [CNT_W-1:0] wr_data,
    input  logic [NCH-1:0]   inv,
    output logic [NCH-1:0]   pwm,
    output logic [CNT_W-1:0] cnt_out,
    output logic             dir,
    output logic             upd_evt,
    output logic             running
);

    localparam logic [AW-1:0] AD_CTRL = AW'(A_CTRL);
    localparam logic [AW-1:0] AD_TOP  = AW'(A_TOP);
    localparam logic [AW-1:0] AD_PSC  = AW'(A_PSC);

    logic [CTRL_W-1:0] ctrl_reg, ctrl_next;
    logic [CNT_W-1:0]  top_sh_reg, top_act_reg, cnt_reg;
    logic [PSC_W-1:0]  psc_sh_reg, psc_act_reg, psc_cnt_reg;
    dir_e              dir_reg;
    logic              upd_evt_reg;
    logic              tick, upd_tick, load_act;

    always_comb begin
        tick     = (psc_cnt_reg >= psc_act_reg);
        upd_tick = 1'b0;
        if (ctrl_reg[CTRL_EN] && tick) begin
            if (!ctrl_reg[CTRL_CTR])
                upd_tick = (cnt_reg >= top_act_reg);
            else if (top_act_reg == '0)
                upd_tick = 1'b1;
            else if (dir_reg == DIR_DOWN)
                upd_tick = (cnt_reg <= CNT_W'(1));
            else
                upd_tick = (cnt_reg >= top_act_reg) && (cnt_reg == CNT_W'(1));
        end

        // A software CTRL write in the same cycle overrides the one-shot clear
        ctrl_next = ctrl_reg;
        if (upd_tick && ctrl_reg[CTRL_OS])
            ctrl_next[CTRL_EN] = 1'b0;
        if (wr_en && wr_addr == AD_CTRL)
            ctrl_next = wr_data[CTRL_W-1:0];

        load_act = upd_tick || !ctrl_reg[CTRL_EN];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl_reg    <= '0;
            top_sh_reg  <= '0;
            top_act_reg <= '0;
            psc_sh_reg  <= '0;
            psc_act_reg <= '0;
            psc_cnt_reg <= '0;
            cnt_reg     <= '0;
            dir_reg     <= DIR_UP;
            upd_evt_reg <= 1'b0;
        end else begin
            ctrl_reg    <= ctrl_next;
            upd_evt_reg <= upd_tick;
            if (wr_en && wr_addr == AD_TOP)
                top_sh_reg <= wr_data;
            if (wr_en && wr_addr == AD_PSC)
                psc_sh_reg <= wr_data[PSC_W-1:0];
            if (load_act) begin
                top_act_reg <= top_sh_reg;
                psc_act_reg <= psc_sh_reg;
            end

            // Stopping (or starting) parks the counter at zero
            if (!ctrl_next[CTRL_EN] || !ctrl_reg[CTRL_EN]) begin
                cnt_reg     <= '0;
                psc_cnt_reg <= '0;
                dir_reg     <= DIR_UP;
            end else begin
                psc_cnt_reg <= tick ? '0 : psc_cnt_reg + PSC_W'(1);
                if (!ctrl_reg[CTRL_CTR])
                    dir_reg <= DIR_UP;
                if (tick) begin
                    if (!ctrl_reg[CTRL_CTR]) begin
                        cnt_reg <= (cnt_reg >= top_act_reg) ? '0 : cnt_reg + CNT_W'(1);
                    end else if (top_act_reg == '0) begin
                        cnt_reg <= '0;
                        dir_reg <= DIR_UP;
                    end else if (dir_reg == DIR_DOWN) begin
                        if (cnt_reg <= CNT_W'(1)) begin
                            cnt_reg <= '0;
                            dir_reg <= DIR_UP;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end else if (cnt_reg >= top_act_reg) begin
                        // Turn around at TOP; with TOP=1 the next value is already the bottom
                        cnt_reg <= cnt_reg - CNT_W'(1);
                        dir_reg <= (cnt_reg == CNT_W'(1)) ? DIR_UP : DIR_DOWN;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        localparam logic [AW-1:0] AD_CMP = AW'(A_CMP0 + gi);
        pwm_tmr_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .CLK    (CLK),
            .RST    (RST),
            .cmp_wr (wr_en && wr_addr == AD_CMP),
            .wr_data(wr_data),
            .load   (load_act),
            .cnt    (cnt_reg),
            .en     (ctrl_next[CTRL_EN]),
            .inv    (inv[gi]),
            .pwm    (pwm[gi])
        );
    end

    assign cnt_out = cnt_reg;
    assign dir     = dir_reg;
    assign upd_evt = upd_evt_reg;
    assign running = ctrl_reg[CTRL_EN];

endmodule

// File: tb/tb_pwm_timer_mc.sv
// Directed bench for pwm_timer_mc with NCH=4, CNT_W=16, PSC_W=8.
module tb_pwm_timer_mc;

    localparam int NCH   = 4;
    localparam int CNT_W = 16;
    localparam int AW    = 3;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [CNT_W-1:0] wr_data = '0;
    logic [NCH-1:0]   inv = '0;
    logic [NCH-1:0]   pwm;
    logic [CNT_W-1:0] cnt_out;
    logic             dir, upd_evt, running;

    int checks = 0;
    int errors = 0;
    int m_upd, m_gap, m_to;
    int m_hi[NCH];

    always #5 CLK = ~CLK;

    pwm_timer_mc #(
        .NCH(NCH), .CNT_W(CNT_W), .PSC_W(8)
    ) dut (
        .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .inv(inv), .pwm(pwm), .cnt_out(cnt_out), .dir(dir), .upd_evt(upd_evt), .running(running)
    );

    // Called at a falling edge; returns at the next falling edge with the write captured.
    task automatic write_reg(input logic [AW-1:0] a, input logic [CNT_W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge CLK);
        wr_en = 1'b0;
        $display("WRITE addr=%0d data=%0d", a, d);
    endtask

    // Waits (bounded) for upd_evt, then samples n cycles starting at that cycle.
    task automatic measure(input int n);
        m_upd = 0; m_gap = 0; m_to = 1;
        for (int c = 0; c < NCH; c++) m_hi[c] = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (upd_evt) begin m_to = 0; break; end
        end
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge CLK);
            if (upd_evt) begin
                m_upd++;
                if (i > 0 && m_gap == 0) m_gap = i;
            end
            for (int c = 0; c < NCH; c++) if (pwm[c]) m_hi[c]++;
        end
        $display("MEASURE n=%0d upd=%0d gap=%0d hi=%0d/%0d/%0d/%0d timeout=%0d",
                 n, m_upd, m_gap, m_hi[0], m_hi[1], m_hi[2], m_hi[3], m_to);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (pwm !== 4'b0000) begin errors++; $display("FAIL rst_pwm got %b want 0000", pwm); end
        checks++; if (cnt_out !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", cnt_out); end
        checks++; if (upd_evt !== 1'b0) begin errors++; $display("FAIL rst_upd got %b want 0", upd_evt); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running got %b want 0", running); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL rst_dir got %b want 0", dir); end
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (pwm !== 4'b0000 || running !== 1'b0 || cnt_out !== 16'd0) begin
            errors++; $display("FAIL rst_release got pwm=%b run=%b cnt=%0d want 0000/0/0", pwm, running, cnt_out);
        end
        $display("TEST reset done");
    endtask

    task automatic test_edge;
        write_reg(3'd1, 16'd9);
        write_reg(3'd2, 16'd0);
        write_reg(3'd3, 16'd3);
        write_reg(3'd4, 16'd0);
        write_reg(3'd5, 16'd10);
        write_reg(3'd6, 16'd5);
        write_reg(3'd0, 16'd1);
        measure(30);
        checks++; if (m_to !== 0) begin errors++; $display("FAIL edge_timeout got %0d want 0", m_to); end
        checks++; if (m_gap !== 10) begin errors++; $display("FAIL edge_period got %0d want 10", m_gap); end
        checks++; if (m_upd !== 3) begin errors++; $display("FAIL edge_upd_count got %0d want 3", m_upd); end
        checks++; if (m_hi[0] !== 9) begin errors++; $display("FAIL edge_pwm0_high got %0d want 9", m_hi[0]); end
        checks++; if (m_hi[1] !== 0) begin errors++; $display("FAIL edge_pwm1_cmp0 got %0d want 0", m_hi[1]); end
        checks++; if (m_hi[2] !== 30) begin errors++; $display("FAIL edge_pwm2_cmp_gt_top got %0d want 30", m_hi[2]); end
        checks++; if (m_hi[3] !== 15) begin errors++; $display("FAIL edge_pwm3_high got %0d want 15", m_hi[3]); end
    endtask

    task automatic test_prescale;
        write_reg(3'd0, 16'd0);
        write_reg(3'd1, 16'd4);
        write_reg(3'd2, 16'd2);
        write_reg(3'd3, 16'd2);
        write_reg(3'd7, 16'd0);   // unmapped address: must change nothing
        write_reg(3'd0, 16'd1);
        measure(30);
        checks++; if (m_to !== 0) begin errors++; $display("FAIL psc_timeout got %0d want 0", m_to); end
        checks++; if (m_gap !== 15) begin errors++; $display("FAIL psc_period got %0d want 15", m_gap); end
        checks++; if (m_upd !== 2) begin errors++; $display("FAIL psc_upd_count got %0d want 2", m_upd); end
        checks++; if (m_hi[0] !== 12) begin errors++; $display("FAIL psc_pwm0_high got %0d want 12", m_hi[0]); end
        checks++; if (m_hi[2] !== 30) begin errors++; $display("FAIL psc_pwm2_high got %0d want 30", m_hi[2]); end
        inv = 4'b0001;
        measure(30);
        checks++; if (m_gap !== 15) begin errors++; $display("FAIL psc_inv_period got %0d want 15", m_gap); end
        checks++; if (m_hi[0] !== 18) begin errors++; $display("FAIL psc_inv_pwm0_high got %0d want 18", m_hi[0]); end
    endtask

    task automatic test_center;
        int exp_cnt[10] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1};
        logic exp_dir[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        logic exp_pwm[10] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        int got = 0;
        inv = 4'b0000;
        write_reg(3'd0, 16'd0);
        write_reg(3'd1, 16'd5);
        write_reg(3'd2, 16'd0);
        write_reg(3'd3, 16'd2);
        write_reg(3'd0, 16'd3);
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (upd_evt) begin got = 1; break; end
        end
        checks++; if (got !== 1) begin errors++; $display("FAIL center_start got %0d want 1", got); end
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge CLK);
            checks++; if (cnt_out !== CNT_W'(exp_cnt[i % 10])) begin
                errors++; $display("FAIL center_cnt[%0d] got %0d want %0d", i, cnt_out, exp_cnt[i % 10]);
            end
            checks++; if (dir !== exp_dir[i % 10]) begin
                errors++; $display("FAIL center_dir[%0d] got %b want %b", i, dir, exp_dir[i % 10]);
            end
            checks++; if (pwm[0] !== exp_pwm[i % 10]) begin
                errors++; $display("FAIL center_pwm0[%0d] got %b want %b", i, pwm[0], exp_pwm[i % 10]);
            end
            checks++; if (upd_evt !== (i % 10 == 0)) begin
                errors++; $display("FAIL center_upd[%0d] got %b want %b", i, upd_evt, (i % 10 == 0));
            end
        end
        $display("TEST center done");
    endtask

    task automatic test_shadow_and_stop;
        int got = 0;
        int hi_a = 0;
        int hi_b = 0;
        write_reg(3'd0, 16'd0);
        write_reg(3'd1, 16'd9);
        write_reg(3'd3, 16'd3);
        inv = 4'b1000;
        write_reg(3'd0, 16'd1);
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (upd_evt) begin got = 1; break; end
        end
        checks++; if (got !== 1) begin errors++; $display("FAIL shadow_start got %0d want 1", got); end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge CLK);
            if (i == 4) begin
                checks++; if (cnt_out !== 16'd4) begin errors++; $display("FAIL shadow_write_cnt got %0d want 4", cnt_out); end
                wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'd7;
            end
            if (i == 5) wr_en = 1'b0;
            if (pwm[0]) hi_a++;
        end
        for (int i = 10; i < 20; i++) begin
            @(negedge CLK);
            if (i == 10) begin
                checks++; if (upd_evt !== 1'b1) begin errors++; $display("FAIL shadow_upd got %b want 1", upd_evt); end
            end
            if (pwm[0]) hi_b++;
        end
        checks++; if (hi_a !== 3) begin errors++; $display("FAIL shadow_old_duty got %0d want 3", hi_a); end
        checks++; if (hi_b !== 7) begin errors++; $display("FAIL shadow_new_duty got %0d want 7", hi_b); end
        repeat (3) @(negedge CLK);
        checks++; if (cnt_out !== 16'd2) begin errors++; $display("FAIL stop_pre_cnt got %0d want 2", cnt_out); end
        write_reg(3'd0, 16'd0);
        checks++; if (running !== 1'b0 || cnt_out !== 16'd0 || dir !== 1'b0) begin
            errors++; $display("FAIL stop_state got run=%b cnt=%0d dir=%b want 0/0/0", running, cnt_out, dir);
        end
        checks++; if (pwm !== 4'b1000) begin errors++; $display("FAIL stop_pwm got %b want 1000", pwm); end
    endtask

    task automatic test_oneshot;
        int n_upd = 0;
        int first_k = 0;
        write_reg(3'd1, 16'd3);
        write_reg(3'd3, 16'd2);
        inv = 4'b0101;
        @(negedge CLK);
        write_reg(3'd0, 16'd5);
        checks++; if (running !== 1'b1 || cnt_out !== 16'd0) begin
            errors++; $display("FAIL os_start got run=%b cnt=%0d want 1/0", running, cnt_out);
        end
        for (int k = 2; k <= 30; k++) begin
            @(negedge CLK);
            if (upd_evt) begin
                n_upd++;
                if (first_k == 0) first_k = k;
            end
        end
        checks++; if (n_upd !== 1) begin errors++; $display("FAIL os_upd_count got %0d want 1", n_upd); end
        checks++; if (first_k !== 5) begin errors++; $display("FAIL os_upd_time got %0d want 5", first_k); end
        checks++; if (running !== 1'b0 || cnt_out !== 16'd0) begin
            errors++; $display("FAIL os_end got run=%b cnt=%0d want 0/0", running, cnt_out);
        end
        checks++; if (pwm !== 4'b0101) begin errors++; $display("FAIL os_pwm got %b want 0101", pwm); end
    endtask

    task automatic test_reset_mid;
        write_reg(3'd0, 16'd1);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checks++; if (cnt_out !== 16'd0 || running !== 1'b0 || pwm !== 4'b0000 || upd_evt !== 1'b0) begin
            errors++; $display("FAIL mid_rst got cnt=%0d run=%b pwm=%b upd=%b want 0/0/0000/0",
                               cnt_out, running, pwm, upd_evt);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (pwm !== 4'b0101) begin errors++; $display("FAIL mid_idle_pwm got %b want 0101", pwm); end
        write_reg(3'd0, 16'd1);
        // Shadows were cleared, so TOP=0: update on every tick, counter pinned at 0
        for (int k = 2; k <= 6; k++) begin
            @(negedge CLK);
            checks++; if (upd_evt !== 1'b1 || cnt_out !== 16'd0 || pwm !== 4'b0101) begin
                errors++; $display("FAIL mid_top0[%0d] got upd=%b cnt=%0d pwm=%b want 1/0/0101",
                                   k, upd_evt, cnt_out, pwm);
            end
        end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_prescale();
        test_center();
        test_shadow_and_stop();
        test_oneshot();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
